mem_req_master: RTL and testbench
=================================

# mem_req_master

Initiator side of the memory controller request interface. The block queues client commands in a small FIFO and issues them one at a time on the `valid`/`ready` memory bus. It holds each request stable until the controller answers, or until a timeout expires. It then returns one response per command, carrying read data or an error flag, to the client. It sits between an on-chip client (CPU stub, DMA, or test sequencer) and the memory controller.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- DEPTH, 4, command FIFO entries (power of 2, ≥2)
- TIMEOUT, 5, max sampling edges after launch in which `ready` is accepted (≥1)

Ports (one clock `clk`; reset `reset` is synchronous and active-high):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  client command present
- cmd_ready  out  1  FIFO can accept; equals !full
- cmd_addr  in  ADDR_W  command address
- cmd_wdata  in  DATA_W  write data
- cmd_rw  in  1  1 = write, 0 = read
- rsp_valid  out  1  response present
- rsp_ready  in  1  client takes response
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  1 = timed out
- valid  out  1  memory request valid
- ready  in  1  controller completion
- address  out  ADDR_W  memory address
- write_data  out  DATA_W  memory write data
- read_write  out  1  1 = write, 0 = read
- read_data  in  DATA_W  controller read data

## Operation
- FSM states:
  - IDLE: if the FIFO is non-empty at an edge, pop the head, load `address`/`write_data`/`read_write`, set `valid`=1, clear `wait_cnt`, go to REQ.
  - REQ: at each edge, decide on `ready` and `wait_cnt`:
    - `ready`=1: `valid`→0. For a read, capture `read_data` into `rsp_rdata`; for a write, `rsp_rdata`=0. Set `rsp_err`=0, `rsp_valid`=1, go to RESP.
    - `ready`=0 and `wait_cnt`==TIMEOUT-1: timeout. `valid`→0, `rsp_err`=1, `rsp_rdata`=0, `rsp_valid`=1, go to RESP.
    - otherwise: `wait_cnt`++.
  - RESP: on `rsp_ready`, drop `rsp_valid`. If the FIFO is non-empty at that same edge, launch the next request directly (IDLE actions) and go to REQ; otherwise go to IDLE.
- `address`, `write_data`, `read_write` change only at a launch edge. They stay constant through REQ and afterward, including after a timeout.
- `ready` while `valid`=0 is ignored.
- The FIFO accepts on `cmd_valid && cmd_ready`. Push and pop in the same edge are allowed when full; `cmd_ready` stays at its pre-edge value that cycle.
- Ordering: responses return in command order, exactly one per accepted command.

## Timing
- Reset values: `valid`=0, `address`=0, `write_data`=0, `read_write`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, FIFO empty, `cmd_ready`=1 the cycle after reset. `wait_cnt`=0, state IDLE.
- Latency: command accepted at edge N into an empty FIFO with FSM in IDLE → `valid` high after edge N+1.
- Completion: `ready` sampled at edge L+k (1≤k≤TIMEOUT, launch at L) → `rsp_valid` high after L+k.
- Timeout: no `ready` at L+1..L+TIMEOUT → error response after edge L+TIMEOUT.
- Back-to-back: the minimum gap is one cycle of `valid`=0 between transactions (the RESP cycle).
- Wrap-around: FIFO pointers wrap modulo DEPTH. Full is count==DEPTH, empty is count==0.
- Reset mid-operation: the in-flight request is abandoned, the FIFO is flushed, and all outputs take reset values after the reset edge. No response is issued for dropped commands.

## Structure
- Shared package `mem_req_pkg`:
  - FSM state enum `{IDLE, REQ, RESP}`
  - constants `MEM_RD`=0, `MEM_WR`=1
  - packed `mem_cmd_t` {addr, wdata, rw}
- Sub-module `mem_req_fifo`: synchronous FIFO of `mem_cmd_t`, DEPTH entries, with full/empty/count outputs.
- Top-level `mem_req_master` holds the FSM, `wait_cnt` (width `$clog2(TIMEOUT+1)`), request registers and response registers.

## Test plan
- Single read: cmd addr=0x100 rw=0; responder asserts `ready` 2 cycles after `valid` with read_data=0xDEADBEEF → rsp_rdata=0xDEADBEEF, rsp_err=0; `address` stable at 0x100 while `valid && !ready`.
- Single write: cmd addr=0x40, wdata=0x12345678, rw=1; `ready` at k=1 → write_data=0x12345678 while `valid`; rsp_rdata=0, rsp_err=0.
- Timeout: responder never asserts `ready` → `valid` drops exactly TIMEOUT(5) edges after launch; rsp_err=1, rsp_rdata=0; `address` unchanged the following cycle.
- FIFO full/backpressure: push 5 commands with rsp_ready=0 and a slow responder (`ready` at k=5) → cmd_ready=0 once 4 commands are queued; all 5 responses return in order with correct data once rsp_ready=1.
- Reset mid-REQ: assert `reset` while `valid`=1 with 2 commands queued → `valid`=0, rsp_valid=0, FIFO empty, cmd_ready=1 after the edge; no stale response appears afterward.
- Protocol check across all tests: bind the `valid |-> ##[1:TIMEOUT] ready` (expected to fail only in the timeout test), address-stability and known-read-data properties to the memory-side ports.

Source files
------------

// File: rtl/mem_req_pkg.sv
// Shared types and constants for the memory request master.
// Contents:
//   state_t   - request FSM state (IDLE, REQ, RESP)
//   MEM_RD/WR - read_write encodings
//   mem_cmd_t - one queued client command {addr, wdata, rw}
package mem_req_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Command storage uses the package widths; the top casts its ports into it.
  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic                  rw;
  } mem_cmd_t;

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous command FIFO of mem_cmd_t entries.
// Ports:
//   clk, reset         - clock, synchronous active-high reset (flushes FIFO)
//   push, push_data    - write one entry (ignored when full unless popping too)
//   pop                - drop head entry (ignored when empty)
//   head               - current head entry (valid when !empty)
//   full, empty, count - occupancy status
module mem_req_fifo
  import mem_req_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  mem_cmd_t         push_data,
  input  logic             pop,
  output mem_cmd_t         head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  mem_cmd_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is 2^n.
  always_comb begin
    pop_ok_s  = pop && !empty;
    // A full FIFO may still take a push in the same edge it pops.
    push_ok_s = push && (!full || pop_ok_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/mem_req_master.sv
// Memory request master: queues client commands and issues them one at a
// time on the valid/ready memory bus, with a per-request timeout, returning
// one in-order response per accepted command.
// Ports:
//   clk, reset                          - clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_addr/
//   cmd_wdata/cmd_rw                    - client command input (cmd_ready = !full)
//   rsp_valid/rsp_ready/rsp_rdata/
//   rsp_err                             - client response (err = timed out)
//   valid/ready/address/write_data/
//   read_write/read_data                - memory controller request bus
module mem_req_master
  import mem_req_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              cmd_rw,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              valid,
  input  logic              ready,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  output logic              read_write,
  input  logic [DATA_W-1:0] read_data
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  // Last sampling edge that may still accept ready is launch + TIMEOUT.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              read_write_q, read_write_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  mem_cmd_t          push_cmd_s;
  mem_cmd_t          head_cmd_s;
  logic              fifo_push_s;
  logic              fifo_pop_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CNT_W-1:0]  fifo_level_unused;
  logic              launch_s;

  assign cmd_ready   = !fifo_full_s;
  assign fifo_push_s = cmd_valid && !fifo_full_s;

  assign push_cmd_s.addr  = MEM_ADDR_W'(cmd_addr);
  assign push_cmd_s.wdata = MEM_DATA_W'(cmd_wdata);
  assign push_cmd_s.rw    = cmd_rw;

  mem_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push_s),
    .push_data (push_cmd_s),
    .pop       (fifo_pop_s),
    .head      (head_cmd_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_level_unused)
  );

  assign valid      = valid_q;
  assign address    = address_q;
  assign write_data = write_data_q;
  assign read_write = read_write_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;

  // Next-state and request/response register logic.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    valid_d      = valid_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    read_write_d = read_write_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    fifo_pop_s   = 1'b0;
    launch_s     = 1'b0;

    case (state_q)
      IDLE: begin
        launch_s = !fifo_empty_s;
      end
      REQ: begin
        if (ready) begin
          valid_d     = 1'b0;
          rsp_rdata_d = (read_write_q == MEM_WR) ? '0 : read_data;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (wait_cnt_q == WAIT_LAST) begin
          valid_d     = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
          // Chain straight into the next request to keep the gap at one cycle.
          launch_s    = !fifo_empty_s;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The request bus fields only ever change here, at a launch edge.
    if (launch_s) begin
      fifo_pop_s   = 1'b1;
      address_d    = ADDR_W'(head_cmd_s.addr);
      write_data_d = DATA_W'(head_cmd_s.wdata);
      read_write_d = head_cmd_s.rw;
      valid_d      = 1'b1;
      wait_cnt_d   = '0;
      state_d      = REQ;
    end else begin
      fifo_pop_s   = 1'b0;
    end
  end

  // State, request and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      valid_q      <= 1'b0;
      address_q    <= '0;
      write_data_q <= '0;
      read_write_q <= MEM_RD;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      valid_q      <= valid_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      read_write_q <= read_write_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_mem_req_master.sv
// Self-checking bench for mem_req_master: directed vector table, backpressure
// and reset sequences, then randomized traffic against a transaction model.
`timescale 1ns/1ps
module tb_mem_req_master;

  localparam int T = 5;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
  logic [31:0] cmd_addr = 32'h0, cmd_wdata = 32'h0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic        valid, ready = 1'b0, read_write;
  logic [31:0] address, write_data, read_data = 32'h0;

  mem_req_master #(.ADDR_W(32), .DATA_W(32), .DEPTH(D), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_rw(cmd_rw),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .valid(valid), .ready(ready), .address(address), .write_data(write_data),
    .read_write(read_write), .read_data(read_data)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [31:0] wdata; logic rw; } tcmd_t;
  typedef struct packed { logic err; logic [31:0] rdata; logic [7:0] len; } trsp_t;
  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rw;
    int          k;        // edges after launch at which ready is given (>T: never)
    logic [31:0] rd;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_len;  // edges valid stays high
  } vec_t;

  int checks = 0, failures = 0, cyc = 0;

  // Transaction model state
  tcmd_t       src_q[$];      // commands waiting to be offered
  tcmd_t       exp_cmd_q[$];  // accepted, not yet launched (FIFO contents)
  int          k_q[$];
  logic [31:0] rd_q[$];
  trsp_t       rsp_exp_q[$];  // completed, not yet consumed
  trsp_t       log_q[$];      // consumed responses
  int          occ = 0;
  bit          in_req = 0, have_cur = 0, acc_pend = 0, take_pend = 0;
  bit          rnd_mode = 0, saw_full = 0;
  int          rsp_mode = 1;  // 0: never ready, 1: always ready, 2: random
  tcmd_t       cur;
  int          c, k, eff;
  logic [31:0] rdv;
  int          last_acc_cyc = 0, last_launch_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: observe at the falling edge, update the model, drive inputs.
  task automatic tick();
    trsp_t r;
    trsp_t f;
    tcmd_t n;
    @(negedge clk);
    cyc++;
    if (reset) begin
      src_q.delete(); exp_cmd_q.delete(); k_q.delete(); rd_q.delete(); rsp_exp_q.delete();
      occ = 0; in_req = 0; have_cur = 0; acc_pend = 0; take_pend = 0;
    end else begin
      if (take_pend && rsp_exp_q.size() != 0) log_q.push_back(rsp_exp_q.pop_front());
      if (in_req) begin
        if (valid !== 1'b1) begin
          chk("valid_len", 64'(c - 1), 64'(eff));
          r.err   = (k > T);
          r.rdata = (r.err || cur.rw) ? 32'h0 : rdv;
          r.len   = 8'(c - 1);
          rsp_exp_q.push_back(r);
          in_req = 0;
        end else begin
          chk("valid_within_timeout", 64'(c <= eff), 64'd1);
        end
      end else if (valid === 1'b1) begin
        last_launch_cyc = cyc;
        if (exp_cmd_q.size() == 0) begin
          chk("launch_has_cmd", 64'd0, 64'd1);
          cur = '0;
        end else begin
          cur = exp_cmd_q.pop_front();
          occ--;
        end
        have_cur = 1; in_req = 1; c = 1;
        k   = (k_q.size() != 0) ? k_q.pop_front() : int'($urandom_range(1, 7));
        rdv = (rd_q.size() != 0) ? rd_q.pop_front() : $urandom;
        eff = (k > T) ? T : k;
      end
      if (acc_pend) begin
        exp_cmd_q.push_back(src_q.pop_front());
        occ++;
        last_acc_cyc = cyc;
      end
    end

    // Compare DUT outputs with the model
    chk("valid", 64'(valid), 64'(in_req));
    chk("rsp_valid", 64'(rsp_valid), 64'(rsp_exp_q.size() != 0));
    if (rsp_exp_q.size() != 0 && rsp_valid === 1'b1) begin
      f = rsp_exp_q[0];
      chk("rsp_err", 64'(rsp_err), 64'(f.err));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(f.rdata));
    end
    chk("cmd_ready", 64'(cmd_ready), 64'(occ < D));
    if (occ >= D) saw_full = 1;
    if (have_cur) begin
      chk("address", 64'(address), 64'(cur.addr));
      chk("write_data", 64'(write_data), 64'(cur.wdata));
      chk("read_write", 64'(read_write), 64'(cur.rw));
    end else begin
      chk("address_rst", 64'(address), 64'd0);
      chk("write_data_rst", 64'(write_data), 64'd0);
      chk("read_write_rst", 64'(read_write), 64'd0);
    end

    // Drive next inputs
    if (rnd_mode && src_q.size() == 0 && $urandom_range(0, 2) == 0) begin
      n.addr  = $urandom;
      n.wdata = $urandom;
      n.rw    = 1'($urandom_range(0, 1));
      src_q.push_back(n);
    end
    if (src_q.size() != 0) begin
      cmd_valid = 1'b1;
      cmd_addr  = src_q[0].addr;
      cmd_wdata = src_q[0].wdata;
      cmd_rw    = src_q[0].rw;
    end else begin
      cmd_valid = 1'b0;
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      cmd_rw    = 1'($urandom_range(0, 1));
    end
    acc_pend = cmd_valid && (cmd_ready === 1'b1);
    if (in_req) begin
      ready     = (c == k);
      read_data = (c == k) ? rdv : $urandom;
      c++;
    end else begin
      // ready noise while no request is outstanding must be ignored
      ready     = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      read_data = $urandom;
    end
    case (rsp_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = ($urandom_range(0, 3) != 0);
    endcase
    take_pend = (rsp_valid === 1'b1) && rsp_ready;
  endtask

  vec_t vecs[7];

  initial begin
    int    n;
    trsp_t g;
    logic [31:0] exp_rd;

    vecs[0] = '{"single_read",   32'h0000_0100, 32'h0000_0000, 1'b0, 2, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 2};
    vecs[1] = '{"single_write",  32'h0000_0040, 32'h1234_5678, 1'b1, 1, 32'hCAFE_F00D, 1'b0, 32'h0000_0000, 1};
    vecs[2] = '{"timeout_read",  32'h0000_0200, 32'h0000_0000, 1'b0, 7, 32'h5555_5555, 1'b1, 32'h0000_0000, 5};
    vecs[3] = '{"ready_last",    32'h0000_0300, 32'h0000_0000, 1'b0, 5, 32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5, 5};
    vecs[4] = '{"ready_late",    32'h0000_0304, 32'h0000_0000, 1'b0, 6, 32'h1111_1111, 1'b1, 32'h0000_0000, 5};
    vecs[5] = '{"timeout_write", 32'h0000_0044, 32'h8765_4321, 1'b1, 7, 32'h2222_2222, 1'b1, 32'h0000_0000, 5};
    vecs[6] = '{"write_k3",      32'h0000_0048, 32'hFFFF_FFFF, 1'b1, 3, 32'h1212_1212, 1'b0, 32'h0000_0000, 3};

    // Reset values
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    tick();

    // Directed single transactions
    for (int i = 0; i < 7; i++) begin
      n = log_q.size();
      src_q.push_back({vecs[i].addr, vecs[i].wdata, vecs[i].rw});
      k_q.push_back(vecs[i].k);
      rd_q.push_back(vecs[i].rd);
      for (int j = 0; j < 60 && log_q.size() == n; j++) tick();
      if (log_q.size() == n) begin
        chk({vecs[i].name, "_no_response"}, 64'd0, 64'd1);
      end else begin
        g = log_q[n];
        chk({vecs[i].name, "_err"}, 64'(g.err), 64'(vecs[i].exp_err));
        chk({vecs[i].name, "_rdata"}, 64'(g.rdata), 64'(vecs[i].exp_rdata));
        chk({vecs[i].name, "_len"}, 64'(g.len), 64'(vecs[i].exp_len));
        chk({vecs[i].name, "_latency"}, 64'(last_launch_cyc - last_acc_cyc), 64'd1);
      end
      tick();
      tick();
    end

    // Backpressure: five commands, slow responder, client not taking responses
    rsp_mode = 0;
    saw_full = 0;
    n = log_q.size();
    for (int i = 0; i < 5; i++) begin
      src_q.push_back({32'h0000_1000 + 32'(i * 4), 32'hC000_0000 + 32'(i), 1'(i % 2)});
      k_q.push_back(5);
      rd_q.push_back(32'hB000_0000 + 32'(i));
    end
    for (int j = 0; j < 40 && src_q.size() != 0; j++) tick();
    chk("bp_all_accepted", 64'(src_q.size()), 64'd0);
    tick();
    chk("bp_saw_full", 64'(saw_full), 64'd1);
    chk("bp_cmd_ready_low", 64'(cmd_ready), 64'd0);
    rsp_mode = 1;
    for (int j = 0; j < 200 && log_q.size() < n + 5; j++) tick();
    chk("bp_resp_count", 64'(log_q.size()), 64'(n + 5));
    for (int i = 0; i < 5 && n + i < log_q.size(); i++) begin
      exp_rd = (i % 2 == 1) ? 32'h0 : 32'hB000_0000 + 32'(i);
      chk("bp_err", 64'(log_q[n + i].err), 64'd0);
      chk("bp_rdata", 64'(log_q[n + i].rdata), 64'(exp_rd));
    end
    tick();

    // Reset while a request is outstanding with two commands queued
    n = log_q.size();
    for (int i = 0; i < 3; i++) begin
      src_q.push_back({32'h0000_2000 + 32'(i), 32'h0, 1'b0});
      k_q.push_back(7);
    end
    for (int j = 0; j < 30 && !(in_req && occ == 2); j++) tick();
    chk("rst_setup", 64'(in_req && occ == 2), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_valid", 64'(valid), 64'd0);
    chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
    repeat (20) tick();
    chk("rst_no_stale_rsp", 64'(log_q.size()), 64'(n));

    // Randomized traffic
    rnd_mode = 1;
    rsp_mode = 2;
    repeat (3000) tick();
    rnd_mode = 0;
    rsp_mode = 1;
    for (int j = 0; j < 300 && (src_q.size() != 0 || exp_cmd_q.size() != 0 || in_req ||
                                rsp_exp_q.size() != 0); j++) tick();
    chk("drain_done", 64'(src_q.size() + exp_cmd_q.size() + rsp_exp_q.size() + int'(in_req)), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
